// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares one synchronous memory port between the CPU M-stage and a DMA master.
// Optional DMA starvation protection is enabled by defining DM_ARB_FAIR_EN.
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_byteen,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RESP_C, RESP_D} state_t;

  state_t state, state_next;
  logic   cpu_elig, grant_c, grant_d, c_is_wr, d_is_wr;

  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..15");
    end
  endgenerate

`ifdef DM_ARB_FAIR_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;
  logic       dma_force;

  // A saturated counter hands the next contention to the DMA
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= 4'd0;
    else if (grant_d)
      starve_cnt <= 4'd0;
    else if (d_valid && starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  assign dma_force = d_valid && (starve_cnt == LIMIT);
`endif

  always_comb begin
    c_is_wr  = |c_byteen;
    d_is_wr  = |d_byteen;
    // The CPU request held during RESP_C is the one completing, not a new access
    cpu_elig = c_req && (state != RESP_C);
`ifdef DM_ARB_FAIR_EN
    grant_c  = reset && cpu_elig && !dma_force;
`else
    grant_c  = reset && cpu_elig;
`endif
    grant_d  = reset && d_valid && !grant_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (grant_c && !c_is_wr)
      state_next = RESP_C;
    else if (grant_d && !d_is_wr)
      state_next = RESP_D;
  end

  always_comb begin
    mem_en     = grant_c || grant_d;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_byteen = 4'h0;
    if (grant_c) begin
      mem_addr   = c_addr;
      mem_wdata  = c_wdata;
      mem_byteen = c_byteen;
    end else if (grant_d) begin
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
      mem_byteen = d_byteen;
    end
    c_stall  = c_req && !(grant_c && c_is_wr) && (state != RESP_C);
    c_rdata  = (state == RESP_C) ? mem_rdata : 32'h0;
    d_ready  = grant_d;
    d_rvalid = (state == RESP_D);
    d_rdata  = (state == RESP_D) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Define DM_ARB_FAIR_EN for both files to exercise the starvation-protection build.
`timescale 1ns/1ps
module tb_dm_port_arbiter;

`ifdef DM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        c_req = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic [3:0]  c_byteen = '0;
  logic [31:0] c_rdata;
  logic        c_stall;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_byteen = '0;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] env_mem [16];

  dm_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_byteen(c_byteen),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteen(d_byteen), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byteen(mem_byteen), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // 16-word synchronous memory, byte-writable, read data one cycle after issue
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_byteen != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteen[b]) env_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= env_mem[mem_addr[5:2]];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; c_req = 1'b1; c_byteen = 4'h0; c_addr = 32'h10;
    d_valid = 1'b1; d_byteen = 4'h0; d_addr = 32'h20;
    @(negedge clk);
    n_checks++;
    if ({mem_en, d_ready, d_rvalid, c_stall} !== 4'b0001)
      $display("[TB] FAIL reset_ctrl: got %b required 0001", {mem_en, d_ready, d_rvalid, c_stall});
    else n_pass++;
    n_checks++;
    if (c_rdata !== 32'h0 || d_rdata !== 32'h0)
      $display("[TB] FAIL reset_rdata: got %h/%h required 0/0", c_rdata, d_rdata);
    else n_pass++;
    c_req = 1'b0; d_valid = 1'b0;
    #1;
    n_checks++;
    if (c_stall !== 1'b0) $display("[TB] FAIL reset_stall_idle: got %b required 0", c_stall);
    else n_pass++;
    next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] w, input string name);
    c_req = 1'b1; c_addr = a; c_wdata = w; c_byteen = 4'hF;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_byteen, mem_addr, mem_wdata, c_stall} !== {1'b1, 4'hF, a, w, 1'b0})
      $display("[TB] FAIL %s: got en=%b be=%h a=%h w=%h stall=%b required 1 f %h %h 0",
               name, mem_en, mem_byteen, mem_addr, mem_wdata, c_stall, a, w);
    else n_pass++;
    next_cycle();
    c_req = 1'b0; c_byteen = 4'h0;
  endtask

  task automatic test_cpu_write();
    cpu_write(32'h10, 32'hDEADBEEF, "cpu_write");
    cpu_write(32'h20, 32'h12345678, "cpu_write_preload");
  endtask

  task automatic test_cpu_read();
    c_req = 1'b1; c_addr = 32'h10; c_byteen = 4'h0;
    @(negedge clk);
    n_checks++;
    if ({c_stall, mem_en, mem_addr} !== {1'b1, 1'b1, 32'h10})
      $display("[TB] FAIL cpu_read_issue: got stall=%b en=%b a=%h required 1 1 00000010", c_stall, mem_en, mem_addr);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({c_stall, mem_en, c_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF})
      $display("[TB] FAIL cpu_read_done: got stall=%b en=%b rd=%h required 0 0 deadbeef", c_stall, mem_en, c_rdata);
    else n_pass++;
    next_cycle();
    c_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (c_rdata !== 32'h0) $display("[TB] FAIL cpu_rdata_idle: got %h required 0", c_rdata);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_contention();
    c_req = 1'b1; c_addr = 32'h10; c_byteen = 4'h0;
    d_valid = 1'b1; d_addr = 32'h20; d_byteen = 4'h0;
    @(negedge clk);
    n_checks++;
    if ({mem_addr, d_ready, c_stall} !== {32'h10, 1'b0, 1'b1})
      $display("[TB] FAIL contend_n: got a=%h rdy=%b stall=%b required 00000010 0 1", mem_addr, d_ready, c_stall);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({d_ready, mem_addr, c_rdata, c_stall} !== {1'b1, 32'h20, 32'hDEADBEEF, 1'b0})
      $display("[TB] FAIL contend_n1: got rdy=%b a=%h crd=%h stall=%b required 1 00000020 deadbeef 0",
               d_ready, mem_addr, c_rdata, c_stall);
    else n_pass++;
    next_cycle();
    c_req = 1'b0; d_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({d_rvalid, d_rdata, mem_en} !== {1'b1, 32'h12345678, 1'b0})
      $display("[TB] FAIL contend_n2: got rv=%b drd=%h en=%b required 1 12345678 0", d_rvalid, d_rdata, mem_en);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({d_rvalid, d_rdata} !== {1'b0, 32'h0})
      $display("[TB] FAIL dma_rvalid_drop: got rv=%b drd=%h required 0 0", d_rvalid, d_rdata);
    else n_pass++;
  endtask

  // CPU writes every cycle while the DMA keeps a write pending
  task automatic test_starvation();
    int grants = 0;
    logic exp_rdy;
    c_req = 1'b1; c_addr = 32'h04; c_byteen = 4'hF;
    d_valid = 1'b1; d_addr = 32'h08; d_byteen = 4'hF;
    for (int i = 0; i < 20; i++) begin
      c_wdata = $urandom; d_wdata = $urandom;
      exp_rdy = FAIR && ((i % (LIMIT + 1)) == LIMIT);
      @(negedge clk);
      n_checks++;
      if ({d_ready, c_stall} !== {exp_rdy, exp_rdy})
        $display("[TB] FAIL starve_cycle%0d: got rdy=%b stall=%b required %b %b", i + 1, d_ready, c_stall, exp_rdy, exp_rdy);
      else n_pass++;
      if (d_ready) grants++;
      next_cycle();
    end
    n_checks++;
    if (grants != (FAIR ? 20 / (LIMIT + 1) : 0))
      $display("[TB] FAIL starve_grants: got %0d required %0d", grants, FAIR ? 20 / (LIMIT + 1) : 0);
    else n_pass++;
    c_req = 1'b0; c_byteen = 4'h0; d_valid = 1'b0; d_byteen = 4'h0;
    next_cycle();
  endtask

  task automatic test_reset_discard();
    d_valid = 1'b1; d_addr = 32'h20; d_byteen = 4'h0;
    @(negedge clk);
    n_checks++;
    if (d_ready !== 1'b1) $display("[TB] FAIL discard_grant: got %b required 1", d_ready);
    else n_pass++;
    next_cycle();
    d_valid = 1'b0; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({d_rvalid, d_rdata} !== {1'b0, 32'h0})
        $display("[TB] FAIL discard_rvalid%0d: got rv=%b drd=%h required 0 0", i, d_rvalid, d_rdata);
      else n_pass++;
      next_cycle();
    end
    reset = 1'b1;
    c_req = 1'b1; c_addr = 32'h10; c_byteen = 4'h0;
    @(negedge clk);
    n_checks++;
    if ({mem_en, c_stall, d_rvalid, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h10})
      $display("[TB] FAIL post_reset_grant: got en=%b stall=%b rv=%b a=%h required 1 1 0 00000010",
               mem_en, c_stall, d_rvalid, mem_addr);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({c_stall, c_rdata} !== {1'b0, 32'hDEADBEEF})
      $display("[TB] FAIL post_reset_read: got stall=%b rd=%h required 0 deadbeef", c_stall, c_rdata);
    else n_pass++;
    next_cycle();
    c_req = 1'b0;
  endtask

  // Transaction-level model: who owns the port this cycle, and which read answers next cycle
  task automatic test_random();
    logic [31:0] ref_mem [16];
    bit          resp_c = 0, resp_d = 0, hold_c = 0, hold_d = 0;
    logic [31:0] val_c = '0, val_d = '0;
    int          starve = 0;
    bit          gc, gd, e_stall;
    logic [31:0] e_addr, e_wdata, e_crd, e_drd;
    logic [3:0]  e_be;
    reset = 1'b0;
    c_req = 1'b0; d_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    for (int i = 0; i < 16; i++) ref_mem[i] = env_mem[i];
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold_c) begin
        c_req    = ($urandom_range(0, 9) < 6);
        c_addr   = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        c_byteen = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        c_wdata  = $urandom;
      end
      if (!hold_d) begin
        d_valid  = ($urandom_range(0, 9) < 5);
        d_addr   = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        d_byteen = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        d_wdata  = $urandom;
      end
      gc = c_req && !resp_c && !(FAIR && d_valid && starve == LIMIT);
      gd = d_valid && !gc;
      e_addr  = gc ? c_addr   : gd ? d_addr   : 32'h0;
      e_wdata = gc ? c_wdata  : gd ? d_wdata  : 32'h0;
      e_be    = gc ? c_byteen : gd ? d_byteen : 4'h0;
      e_stall = c_req && !resp_c && !(gc && c_byteen != 4'h0);
      e_crd   = resp_c ? val_c : 32'h0;
      e_drd   = resp_d ? val_d : 32'h0;
      @(negedge clk);
      n_checks++;
      if ({mem_en, d_ready, d_rvalid, c_stall} !== {gc | gd, gd, resp_d, e_stall})
        $display("[TB] FAIL rand_ctrl@%0d: got en/rdy/rv/stall=%b required %b", cyc,
                 {mem_en, d_ready, d_rvalid, c_stall}, {gc | gd, gd, resp_d, e_stall});
      else n_pass++;
      n_checks++;
      if ({mem_addr, mem_wdata, mem_byteen} !== {e_addr, e_wdata, e_be})
        $display("[TB] FAIL rand_port@%0d: got a=%h w=%h be=%h required %h %h %h", cyc,
                 mem_addr, mem_wdata, mem_byteen, e_addr, e_wdata, e_be);
      else n_pass++;
      n_checks++;
      if ({c_rdata, d_rdata} !== {e_crd, e_drd})
        $display("[TB] FAIL rand_rdata@%0d: got c=%h d=%h required %h %h", cyc, c_rdata, d_rdata, e_crd, e_drd);
      else n_pass++;
      @(posedge clk);
      resp_c = gc && (c_byteen == 4'h0);
      resp_d = gd && (d_byteen == 4'h0);
      if (resp_c) val_c = ref_mem[c_addr[5:2]];
      if (resp_d) val_d = ref_mem[d_addr[5:2]];
      if ((gc || gd) && e_be != 4'h0)
        for (int b = 0; b < 4; b++)
          if (e_be[b]) ref_mem[e_addr[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
      if (gd) starve = 0;
      else if (d_valid && starve < LIMIT) starve++;
      hold_c = e_stall;
      hold_d = d_valid && !gd;
      #1;
    end
    c_req = 1'b0; d_valid = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_contention();
    test_starvation();
    test_reset_discard();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
